// File: rtl/road_playback_gen.sv
// Road source for one trigger tower: per-plane road buffers loaded through a write
// port, replayed on four plane streams in lockstep, closed by a one-cycle end-of-run pulse.
module road_playback_gen #(
    parameter int DW = 30,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    z,
    input  logic [3:0]    phi,
    input  logic          ld_we,
    input  logic [1:0]    ld_plane,
    input  logic [3:0]    ld_z,
    input  logic [3:0]    ld_phi,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_clr,
    input  logic          start,
    output logic          busy,
    output logic          eor,
    output logic [3:0]    ovf,
    output logic [DW-1:0] p0_road_data,
    output logic [DW-1:0] p1_road_data,
    output logic [DW-1:0] p2_road_data,
    output logic [DW-1:0] p3_road_data,
    output logic          p0_road_dv,
    output logic          p1_road_dv,
    output logic          p2_road_dv,
    output logic          p3_road_dv
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   runLen_q, runLen_d;
    logic [AW:0]   cnt_q [4];
    logic [AW:0]   cnt_d [4];
    logic [3:0]    ovf_q, ovf_d;
    logic          eor_q, eor_d;
    logic [3:0]    dv_q, dv_d;
    logic [DW-1:0] data_q [4];
    logic [DW-1:0] data_d [4];
    logic [DW-1:0] mem [4][DEPTH];

    logic          towerHit;
    logic          wrEn;
    logic [AW:0]   maxCnt;

    assign towerHit = ({ld_z, ld_phi} == {z, phi});

    always_comb begin
        maxCnt = '0;
        for (int p = 0; p < 4; p++) begin
            if (cnt_q[p] > maxCnt) begin
                maxCnt = cnt_q[p];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        runLen_d = runLen_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        eor_d    = 1'b0;
        dv_d     = '0;
        data_d   = '{default: '0};
        wrEn     = 1'b0;

        case (state_q)
            IDLE: begin
                // Clear has priority over a same-cycle write; memory contents are kept.
                if (ld_clr) begin
                    cnt_d = '{default: '0};
                    ovf_d = '0;
                end else if (ld_we && towerHit) begin
                    if (cnt_q[ld_plane] == FULL) begin
                        ovf_d[ld_plane] = 1'b1;
                    end else begin
                        wrEn            = 1'b1;
                        cnt_d[ld_plane] = cnt_q[ld_plane] + 1'b1;
                    end
                end
                if (start) begin
                    state_d  = PLAY;
                    idx_d    = '0;
                    runLen_d = maxCnt;
                end
            end
            PLAY: begin
                if (idx_q < runLen_q) begin
                    for (int p = 0; p < 4; p++) begin
                        if (idx_q < cnt_q[p]) begin
                            dv_d[p]   = 1'b1;
                            data_d[p] = mem[p][idx_q[AW-1:0]];
                        end
                    end
                    idx_d = idx_q + 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Two cycles in DONE: the first raises eor, the second drops it and leaves.
                if (!eor_q) begin
                    eor_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            runLen_q <= '0;
            cnt_q    <= '{default: '0};
            ovf_q    <= '0;
            eor_q    <= 1'b0;
            dv_q     <= '0;
            data_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            runLen_q <= runLen_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            eor_q    <= eor_d;
            dv_q     <= dv_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[ld_plane][cnt_q[ld_plane][AW-1:0]] <= ld_data;
        end
    end

    assign busy         = (state_q != IDLE);
    assign eor          = eor_q;
    assign ovf          = ovf_q;
    assign p0_road_dv   = dv_q[0];
    assign p1_road_dv   = dv_q[1];
    assign p2_road_dv   = dv_q[2];
    assign p3_road_dv   = dv_q[3];
    assign p0_road_data = data_q[0];
    assign p1_road_data = data_q[1];
    assign p2_road_data = data_q[2];
    assign p3_road_data = data_q[3];

endmodule

// File: tb/tb_road_playback_gen.sv
// Self-checking bench for road_playback_gen: table-driven loads, hand-written corner
// sequences and randomized loads, all replays compared against a per-plane buffer model.
module tb_road_playback_gen;

    localparam int DW = 30;
    localparam int AW = 6;
    localparam int DEPTH = 64;
    localparam logic [3:0] Z_ID = 4'h5;
    localparam logic [3:0] PHI_ID = 4'hA;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_we, ld_clr, start;
    logic [1:0]    ld_plane;
    logic [3:0]    ld_z, ld_phi;
    logic [DW-1:0] ld_data;
    logic          busy, eor;
    logic [3:0]    ovf;
    logic [DW-1:0] p0Data, p1Data, p2Data, p3Data;
    logic          p0Dv, p1Dv, p2Dv, p3Dv;

    int errors = 0;
    int checks = 0;

    // Reference model: each plane is an ordered list of accepted words plus its overflow flag.
    logic [DW-1:0] modelMem [4][DEPTH];
    int            modelCnt [4];
    logic [3:0]    modelOvf;

    typedef struct {
        logic          we;
        logic          clr;
        logic [1:0]    plane;
        logic [3:0]    lz;
        logic [3:0]    lphi;
        logic [DW-1:0] data;
        logic [3:0]    expOvf;
    } loadVec_t;

    loadVec_t vecs [8];

    road_playback_gen #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .z(Z_ID), .phi(PHI_ID),
        .ld_we(ld_we), .ld_plane(ld_plane), .ld_z(ld_z), .ld_phi(ld_phi),
        .ld_data(ld_data), .ld_clr(ld_clr), .start(start),
        .busy(busy), .eor(eor), .ovf(ovf),
        .p0_road_data(p0Data), .p1_road_data(p1Data),
        .p2_road_data(p2Data), .p3_road_data(p3Data),
        .p0_road_dv(p0Dv), .p1_road_dv(p1Dv), .p2_road_dv(p2Dv), .p3_road_dv(p3Dv)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] planeData(input int p);
        case (p)
            0: return p0Data;
            1: return p1Data;
            2: return p2Data;
            default: return p3Data;
        endcase
    endfunction

    function automatic logic [3:0] dvVec();
        return {p3Dv, p2Dv, p1Dv, p0Dv};
    endfunction

    task automatic modelClear();
        for (int p = 0; p < 4; p++) modelCnt[p] = 0;
        modelOvf = '0;
    endtask

    // One load cycle on the port, mirrored into the model from the loading rules.
    task automatic applyStimulus(input logic we, input logic clr, input logic [1:0] plane,
                                 input logic [3:0] lz, input logic [3:0] lphi,
                                 input logic [DW-1:0] data);
        ld_we = we; ld_clr = clr; ld_plane = plane; ld_z = lz; ld_phi = lphi; ld_data = data;
        tick();
        ld_we = 1'b0; ld_clr = 1'b0;
        if (clr) begin
            modelClear();
        end else if (we && lz == Z_ID && lphi == PHI_ID) begin
            if (modelCnt[plane] == DEPTH) begin
                modelOvf[plane] = 1'b1;
            end else begin
                modelMem[plane][modelCnt[plane]] = data;
                modelCnt[plane]++;
            end
        end
    endtask

    task automatic checkReplay(input string tag, input bit disturb);
        int n;
        n = 0;
        for (int p = 0; p < 4; p++) if (modelCnt[p] > n) n = modelCnt[p];
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput($sformatf("%s busy@start", tag), 64'(busy), 64'd1);
        checkOutput($sformatf("%s dv@start", tag), 64'(dvVec()), 64'd0);
        for (int k = 0; k < n; k++) begin
            if (disturb) begin
                ld_we = 1'b1; ld_clr = k[0]; start = 1'b1; ld_plane = k[1:0];
                ld_z = Z_ID; ld_phi = PHI_ID; ld_data = DW'($urandom);
            end
            tick();
            for (int p = 0; p < 4; p++) begin
                logic          expDv;
                logic [DW-1:0] expData;
                expDv   = (k < modelCnt[p]);
                expData = expDv ? modelMem[p][k] : '0;
                checkOutput($sformatf("%s dv%0d k%0d", tag, p, k), 64'(dvVec()>>p & 4'd1), 64'(expDv));
                checkOutput($sformatf("%s data%0d k%0d", tag, p, k), 64'(planeData(p)), 64'(expData));
            end
            checkOutput($sformatf("%s eor k%0d", tag, k), 64'(eor), 64'd0);
        end
        ld_we = 1'b0; ld_clr = 1'b0; start = 1'b0;
        tick();
        checkOutput($sformatf("%s dv@end", tag), 64'(dvVec()), 64'd0);
        checkOutput($sformatf("%s eor@done", tag), 64'(eor), 64'd0);
        checkOutput($sformatf("%s busy@done", tag), 64'(busy), 64'd1);
        tick();
        checkOutput($sformatf("%s eor pulse", tag), 64'(eor), 64'd1);
        checkOutput($sformatf("%s dv@eor", tag), 64'(dvVec()), 64'd0);
        tick();
        checkOutput($sformatf("%s eor drop", tag), 64'(eor), 64'd0);
        checkOutput($sformatf("%s busy drop", tag), 64'(busy), 64'd0);
        checkOutput($sformatf("%s ovf", tag), 64'(ovf), 64'(modelOvf));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 2'd0, Z_ID, PHI_ID, 30'h0000001, 4'b0000};
        vecs[1] = '{1'b1, 1'b0, 2'd0, Z_ID, PHI_ID, 30'h0000002, 4'b0000};
        vecs[2] = '{1'b1, 1'b0, 2'd0, Z_ID, PHI_ID, 30'h0000003, 4'b0000};
        vecs[3] = '{1'b1, 1'b0, 2'd2, Z_ID, PHI_ID, 30'h3FFFFFFF, 4'b0000};
        vecs[4] = '{1'b1, 1'b0, 2'd1, Z_ID ^ 4'h1, PHI_ID, 30'h0000123, 4'b0000};
        vecs[5] = '{1'b1, 1'b0, 2'd3, Z_ID, PHI_ID ^ 4'h3, 30'h0000456, 4'b0000};
        vecs[6] = '{1'b1, 1'b1, 2'd3, Z_ID, PHI_ID, 30'h0000789, 4'b0000};
        vecs[7] = '{1'b1, 1'b0, 2'd0, Z_ID ^ 4'h8, PHI_ID, 30'h0000ABC, 4'b0000};

        rst_n = 1'b0; ld_we = 1'b0; ld_clr = 1'b0; start = 1'b0;
        ld_plane = '0; ld_z = '0; ld_phi = '0; ld_data = '0;
        modelClear();
        #2;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset eor", 64'(eor), 64'd0);
        checkOutput("reset ovf", 64'(ovf), 64'd0);
        checkOutput("reset dv", 64'(dvVec()), 64'd0);
        checkOutput("reset data", 64'(p0Data | p1Data | p2Data | p3Data), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Matching words on planes 0 and 2, mismatched tower words dropped.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].we, vecs[i].clr, vecs[i].plane, vecs[i].lz, vecs[i].lphi, vecs[i].data);
            checkOutput($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].expOvf));
        end
        checkReplay("basic", 1'b0);

        // Clear beats a same-cycle write; then a mismatched word leaves everything empty.
        for (int i = 6; i < 8; i++) begin
            applyStimulus(vecs[i].we, vecs[i].clr, vecs[i].plane, vecs[i].lz, vecs[i].lphi, vecs[i].data);
            checkOutput($sformatf("vec%0d ovf", i), 64'(ovf), 64'(vecs[i].expOvf));
        end
        checkReplay("empty", 1'b0);

        // Fill plane 1 past its depth.
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b1, 1'b0, 2'd1, Z_ID, PHI_ID, DW'(i));
            if (i == DEPTH - 1) checkOutput("full ovf before", 64'(ovf), 64'd0);
        end
        checkOutput("overflow ovf", 64'(ovf), 64'b0010);
        checkReplay("overflow", 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd0, Z_ID, PHI_ID, '0);
        checkOutput("clr ovf", 64'(ovf), 64'd0);
        checkReplay("after clr", 1'b0);

        // Inputs toggled during PLAY must not disturb the replay.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 2'(i % 3), Z_ID, PHI_ID, DW'($urandom));
        checkReplay("disturbed", 1'b1);
        checkReplay("repeat", 1'b0);

        // Randomized load rounds.
        for (int r = 0; r < 6; r++) begin
            int nLoads;
            nLoads = int'($urandom_range(1, 40));
            for (int i = 0; i < nLoads; i++) begin
                logic hit;
                hit = ($urandom_range(0, 99) < 85);
                applyStimulus(1'b1, ($urandom_range(0, 99) < 3), 2'($urandom_range(0, 3)),
                              hit ? Z_ID : Z_ID ^ 4'($urandom_range(1, 15)), PHI_ID, DW'($urandom));
            end
            checkOutput($sformatf("rand%0d ovf", r), 64'(ovf), 64'(modelOvf));
            checkReplay($sformatf("rand%0d", r), 1'b0);
        end

        // Reset in the middle of a replay.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 2'd0, Z_ID, PHI_ID, DW'(i + 7));
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("midplay dv before reset", 64'(p0Dv), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset dv", 64'(dvVec()), 64'd0);
        checkOutput("midreset data", 64'(p0Data | p1Data | p2Data | p3Data), 64'd0);
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset eor", 64'(eor), 64'd0);
        tick();
        rst_n = 1'b1;
        modelClear();
        tick();
        checkOutput("post reset eor", 64'(eor), 64'd0);
        checkReplay("post reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
